// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add 16x16->32 unsigned multiply sequencer borrowing the shared EX-stage ALU.
// Optional: define ALU_MUL_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module alu_mul_seq #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_mcand,
  input  logic [15:0] req_mplier,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_hi,
  output logic [15:0] resp_lo,
  output logic        alu_own,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] p_hi, m, mc;
  logic [4:0]  cnt;
  logic        own;
  logic        last;
  logic [31:0] sum_shift, shifted;

  // 17-bit ALU result plus the multiplier shifted right by one step
  assign sum_shift = {alu_cout, alu_out, m[15:1]};

  always_comb begin
    state_nx = state;
    last     = 1'b0;
    shifted  = sum_shift;
    case (state)
      IDLE: if (req_valid) state_nx = RUN;
      RUN: begin
`ifdef ALU_MUL_EARLY_TERM_EN
        // After this step, multiplier bits still to consume are m[15-cnt:1]
        last = (cnt == 5'(ITER - 1)) || (((m >> 1) & (16'hFFFF >> (cnt + 5'd1))) == 16'h0000);
        if (last) shifted = sum_shift >> (5'd15 - cnt);
`else
        last = (cnt == 5'(ITER - 1));
`endif
        if (last) state_nx = DONE;
      end
      DONE: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= 1'b0;
      p_hi    <= 16'h0000;
      m       <= 16'h0000;
      mc      <= 16'h0000;
      cnt     <= 5'd0;
      resp_hi <= 16'h0000;
      resp_lo <= 16'h0000;
    end else begin
      state <= state_nx;
      own   <= (state_nx == RUN);
      case (state)
        IDLE: if (req_valid) begin
          mc   <= req_mcand;
          m    <= req_mplier;
          p_hi <= 16'h0000;
          cnt  <= 5'd0;
        end
        RUN: begin
          {p_hi, m} <= shifted;
          cnt       <= cnt + 5'd1;
          if (last) {resp_hi, resp_lo} <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign alu_own    = own;
  assign alu_op     = 4'b0000;
  assign alu_cin    = 1'b0;
  assign alu_a      = own ? p_hi : 16'h0000;
  assign alu_b      = (own && m[0]) ? mc : 16'h0000;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign stall      = own || ((state == DONE) && !resp_ready);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq with an arithmetic product/latency model.
module tb_alu_mul_seq;

`ifdef ALU_MUL_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [15:0] req_mcand, req_mplier, resp_hi, resp_lo;
  logic        alu_own, alu_cin, alu_cout, stall;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared EX ALU: add with carry
  assign {alu_cout, alu_out} = (alu_op == 4'b0000) ?
      ({1'b0, alu_a} + {1'b0, alu_b} + {16'h0000, alu_cin}) : 17'h00000;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mcand(req_mcand), .req_mplier(req_mplier),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout), .stall(stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from accept to first resp_valid
  function automatic int lat_of(input logic [15:0] mp);
    int h;
    h = 0;
    for (int i = 0; i < 16; i++) if (mp[i]) h = i + 1;
    if (ET) return (h == 0) ? 2 : 1 + h;
    return 17;
  endfunction

  // Cycle-by-cycle reference: one transaction in flight, expected outputs from the rules
  bit          m_busy, inrun;
  int          m_acc, m_lat, cyc;
  logic [31:0] m_exp, m_last;
  initial begin
    m_busy = 1'b0; m_last = 32'h0; cyc = 0; m_acc = 0; m_lat = 0; m_exp = 32'h0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_last = 32'h0;
      end else begin
        cyc++;
        if (m_busy) begin
          inrun = (cyc < m_acc + m_lat);
          chk("mon_own", 32'(alu_own), 32'(inrun));
          chk("mon_resp_valid", 32'(resp_valid), 32'(!inrun));
          chk("mon_req_ready", 32'(req_ready), 32'd0);
          chk("mon_stall", 32'(stall), 32'(inrun || !resp_ready));
          chk("mon_product", {resp_hi, resp_lo}, inrun ? m_last : m_exp);
          if (inrun) chk("mon_alu_ctl", {27'h0, alu_cin, alu_op}, 32'd0);
          if (!inrun && resp_ready) begin
            m_busy = 1'b0;
            m_last = m_exp;
          end
        end else begin
          chk("mon_idle_own", 32'(alu_own), 32'd0);
          chk("mon_idle_resp_valid", 32'(resp_valid), 32'd0);
          chk("mon_idle_req_ready", 32'(req_ready), 32'd1);
          chk("mon_idle_stall", 32'(stall), 32'd0);
          chk("mon_idle_product", {resp_hi, resp_lo}, m_last);
          if (req_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_exp  = 32'(req_mcand) * 32'(req_mplier);
            m_lat  = lat_of(req_mplier);
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int k;
    bit acc;
    k = 0; acc = 1'b0;
    req_mcand = a; req_mplier = b; req_valid = 1'b1;
    while (!acc && k < 400) begin
      @(negedge clk);
      k++;
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input bit lit,
                         input logic [31:0] lit_prod, input int lit_lat, input bit bp);
    int k, lat, own_n;
    bit got, first;
    issue(a, b);
    k = 0; lat = 0; own_n = 0; got = 1'b0; first = 1'b1;
    while (!got && k < 400) begin
      @(negedge clk);
      k++;
      if (alu_own && alu_op == 4'b0000) own_n++;
      if (resp_valid && first) begin first = 1'b0; lat = k; end
      if (resp_valid && resp_ready) got = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    if (lit) begin
      chk("lit_product", {resp_hi, resp_lo}, lit_prod);
      chk("lit_latency", 32'(lat), 32'(lit_lat));
      chk("lit_own_cycles", 32'(own_n), 32'(lit_lat - 1));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, b;
    int k;
    req_valid = 1'b0; req_mcand = 16'h0; req_mplier = 16'h0; resp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_own", 32'(alu_own), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_product", {resp_hi, resp_lo}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_txn(16'd3, 16'd5, 1'b1, 32'h0000000F, ET ? 4 : 17, 1'b0);
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, 17, 1'b0);
    run_txn(16'h1234, 16'h0000, 1'b1, 32'h00000000, ET ? 2 : 17, 1'b0);
    run_txn(16'h0000, 16'hBEEF, 1'b1, 32'h00000000, 17, 1'b0);

    // Backpressure: DONE held 10 cycles with a competing request present
    resp_ready = 1'b0;
    issue(16'h00FF, 16'h0101);
    k = 0;
    while (!resp_valid && k < 40) begin @(negedge clk); k++; end
    chk("bp_reached_done", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_mcand = 16'd7; req_mplier = 16'd7;
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_product", {resp_hi, resp_lo}, 32'h0000FFFF);
      chk("bp_stall", 32'(stall), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {30'h0, req_ready, resp_valid}, 32'd2);
    run_txn(16'd2, 16'd3, 1'b1, 32'h00000006, ET ? 3 : 17, 1'b0);

    // Asynchronous reset in the 8th RUN cycle
    issue(16'hABCD, 16'h1234);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_own", 32'(alu_own), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    #1 rst_n = 1'b1;
    run_txn(16'd7, 16'd9, 1'b1, 32'h0000003F, ET ? 5 : 17, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 15))
        0: a = 16'h0000;
        1: b = 16'h0000;
        2: a = 16'hFFFF;
        3: b = 16'hFFFF;
        4: b = 16'(1 << $urandom_range(0, 15));
        default: ;
      endcase
      run_txn(a, b, 1'b0, 32'h0, 0, 1'b1);
    end

    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer for unsigned 16x16→32 multiply (MUL/MULH) on the shared 16-bit EX-stage ALU, using radix-2 shift-add.
- While busy it owns the ALU's A/B/Cin/ALUop inputs through an ownership select and stalls the pipeline.
- Sits beside the ALU in EX; the decode/EX control issues a request and retires the result through a valid/ready handshake.

Parameters:
- ITER, 16, number of shift-add iterations; equals the operand width; only 16 is supported.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  multiply request valid
- req_ready  out  1  sequencer can accept a request
- req_mcand  in  16  multiplicand
- req_mplier  in  16  multiplier
- resp_valid  out  1  product valid
- resp_ready  in  1  consumer accepts product
- resp_hi  out  16  product[31:16]
- resp_lo  out  16  product[15:0]
- alu_own  out  1  1 = sequencer drives the shared ALU inputs (EX mux select)
- alu_a  out  16  ALU input A
- alu_b  out  16  ALU input B
- alu_cin  out  1  ALU carry-in
- alu_op  out  4  ALU opcode
- alu_out  in  16  ALU sum output
- alu_cout  in  1  ALU carry-out
- stall  out  1  pipeline stall request

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid=0; alu_own=0; stall=0; resp_hi/resp_lo=0; internal P_hi, M, MC, cnt = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch MC=req_mcand, M=req_mplier, P_hi=0, cnt=0; go to RUN next edge.
  - No ALU ownership in IDLE.
- RUN:
  - alu_own=1, stall=1, req_ready=0.
  - ALU drive each cycle: alu_op=4'b0000 (add), alu_a=P_hi, alu_b = M[0] ? MC : 16'h0000, alu_cin=0.
  - Each edge: {P_hi, M} <= {alu_cout, alu_out, M[15:1]} (17-bit sum shifted right one into the 32-bit product register); cnt <= cnt+1.
  - When cnt==ITER-1 at the edge: go to DONE.
- Latency: request accepted at edge t; RUN occupies cycles t+1..t+16; resp_valid=1 from cycle t+17.
- DONE:
  - resp_valid=1; resp_hi=P_hi, resp_lo=M; alu_own=0; stall=1 while resp_ready=0.
  - On resp_ready=1: return to IDLE next edge; resp_valid drops the same edge.
  - resp_hi/resp_lo hold their last value in IDLE until the next DONE.
- Backpressure: DONE holds indefinitely with product stable; no new request is accepted.
- Request with req_valid=1 outside IDLE: ignored (req_ready=0); the requester must hold it.
- Back-to-back: a request presented in the IDLE cycle immediately after DONE is accepted; minimum issue interval is 18 cycles with resp_ready tied high.
- Arithmetic: unsigned only. Carry into P_hi uses alu_cout, which must be used because the sum can reach 17 bits. Zero and Neg from the ALU are ignored.
- Boundaries:
  - mplier=0 or mcand=0 → product 0, full latency.
  - 0xFFFF×0xFFFF → 0xFFFE0001, no overflow loss.
- Reset mid-RUN or mid-DONE: immediate return to IDLE; partial product is discarded; alu_own and stall drop asynchronously.
- alu_own is a registered state decode and is glitch-free.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, if the remaining multiplier bits M[15-cnt:0] are all zero at the start of a cycle, go directly to DONE.
  - The final product is {P_hi, M} shifted right by the remaining count (ITER-cnt) with zero fill, aligned in the DONE entry edge.
  - Latency = 1 + (index of the highest set mplier bit + 1) cycles; mplier=0 reaches DONE after 1 RUN cycle.
- Undefined: always ITER RUN cycles.
- Product values are identical either way.

Test Plan:
- mcand=3, mplier=5, resp_ready=1 → resp_valid exactly 17 cycles after accept; hi=0x0000, lo=0x000F; alu_own=1 for exactly 16 cycles with alu_op=0000 throughout.
- mcand=0xFFFF, mplier=0xFFFF → hi=0xFFFE, lo=0x0001; checks that alu_cout is carried.
- mcand=0x1234, mplier=0 → hi=lo=0; without the macro latency is 17; with ALU_MUL_EARLY_TERM_EN latency is 2.
- resp_ready held 0 for 10 cycles after DONE → resp_valid, hi/lo and stall stable; req_valid during that time not accepted; release → IDLE next edge, next request accepted.
- rst_n pulsed low at RUN cycle 8 (mid-cycle, asynchronous) → alu_own, stall and resp_valid drop without waiting for an edge, req_ready=1; the following request 7×9 returns lo=0x003F.
- Random 1000 unsigned pairs against a reference model, random resp_ready backpressure, with and without the macro → all products match.
